// File: rtl/dgiota_trim_ctrl_pkg.sv
// ============================================================================
// Module   : dgiota_pkg
// Brief    : Shared types and constants for the digital-OTA trim sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dgiota_pkg;

  // Default trim DAC width and settle wait
  localparam int DGIOTA_TRIM_W     = 6;
  localparam int DGIOTA_SETTLE_DEF = 16;

  // Mid-scale trim code: only the MSB set, the SAR starting point
  localparam logic [DGIOTA_TRIM_W-1:0] DGIOTA_TRIM_MID =
    {1'b1, {(DGIOTA_TRIM_W-1){1'b0}}};

  // Sequencer states
  typedef enum logic [2:0] {
    TS_IDLE   = 3'd0,
    TS_WARM   = 3'd1,
    TS_TRIAL  = 3'd2,
    TS_SETTLE = 3'd3,
    TS_SAMPLE = 3'd4,
    TS_DONE   = 3'd5
  } trim_state_t;

endpackage

`default_nettype wire

// File: rtl/dgiota_trim_ctrl_if.sv
// ============================================================================
// Module   : dgiota_trim_ctrl_if
// Brief    : Pin-side bundle of the trim sequencer: requests, comparator
//            feedback, trim/calibration controls and status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dgiota_trim_ctrl_if #(
  parameter int TRIM_W = 6
) ();

  logic              ena;
  logic              start;
  logic              manual_en;
  logic [TRIM_W-1:0] manual_code;
  logic              cmp_in;
  logic [TRIM_W-1:0] trim_code;
  logic              cal_mode;
  logic              ota_en;
  logic              busy;
  logic              done;
  logic [TRIM_W-1:0] cal_code;

  // Pin / analog side: drives requests and comparator, observes controls
  modport master (
    output ena, start, manual_en, manual_code, cmp_in,
    input  trim_code, cal_mode, ota_en, busy, done, cal_code
  );

  // Sequencer side
  modport slave (
    input  ena, start, manual_en, manual_code, cmp_in,
    output trim_code, cal_mode, ota_en, busy, done, cal_code
  );

endinterface

`default_nettype wire

// File: rtl/dgiota_trim_ctrl_sync2.sv
// ============================================================================
// Module   : dgiota_sync2
// Brief    : Two-flop synchroniser for a single asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dgiota_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/dgiota_trim_ctrl.sv
// ============================================================================
// Module   : dgiota_trim_ctrl
// Brief    : SAR offset-trim sequencer for the digital OTA. Searches the
//            binary-weighted trim code using the OTA comparator as feedback,
//            holds the result and supports a manual code override.
// Options  : DGIOTA_TRIM_MAJORITY_EN - 3-cycle sample with 2-of-3 vote.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dgiota_trim_ctrl
  import dgiota_pkg::*;
#(
  parameter int TRIM_W     = DGIOTA_TRIM_W,
  parameter int SETTLE_CYC = DGIOTA_SETTLE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dgiota_trim_ctrl_if.slave bus
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [2:0] S_IDLE   = TS_IDLE;
  localparam logic [2:0] S_WARM   = TS_WARM;
  localparam logic [2:0] S_TRIAL  = TS_TRIAL;
  localparam logic [2:0] S_SETTLE = TS_SETTLE;
  localparam logic [2:0] S_SAMPLE = TS_SAMPLE;
  localparam logic [2:0] S_DONE   = TS_DONE;

  localparam logic [TRIM_W-1:0] c_TRIM_MID   = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [TRIM_W-1:0] c_TRIM_ONE   = {{(TRIM_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  c_IDX_TOP    = IDX_W'(TRIM_W - 1);
  localparam logic [IDX_W-1:0]  c_IDX_ONE    = IDX_W'(1);
  localparam logic [7:0]        c_SETTLE_LD  = 8'(SETTLE_CYC - 1);
`ifdef DGIOTA_TRIM_MAJORITY_EN
  localparam logic [7:0]        c_SAMPLE_LD  = 8'd2;
`else
  localparam logic [7:0]        c_SAMPLE_LD  = 8'd0;
`endif

  logic [2:0]        r_state;
  logic [7:0]        r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [TRIM_W-1:0] r_trim;
  logic [TRIM_W-1:0] r_cal;
  logic              r_cal_mode;
  logic              r_done;
  logic              r_ota_en;

  logic              w_cmp;
  logic              w_cmp_dec;
  logic [TRIM_W-1:0] w_bit_mask;
  logic [TRIM_W-1:0] w_decided_code;

  dgiota_sync2 u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.cmp_in),
    .q     (w_cmp)
  );

`ifdef DGIOTA_TRIM_MAJORITY_EN
  logic [1:0] r_votes;

  // Keep the first two comparator samples of the SAMPLE window for the vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_votes <= 2'b00;
    end else if (r_state == S_SAMPLE && r_cnt != 8'd0) begin
      r_votes <= {r_votes[0], w_cmp};
    end
  end

  assign w_cmp_dec = (r_votes[1] & r_votes[0]) |
                     (r_votes[1] & w_cmp) |
                     (r_votes[0] & w_cmp);
`else
  assign w_cmp_dec = w_cmp;
`endif

  assign w_bit_mask     = c_TRIM_ONE << r_idx;
  // Comparator high means the code is too large: drop the bit under trial
  assign w_decided_code = w_cmp_dec ? (r_trim & ~w_bit_mask) : r_trim;

  // Sequencer: SAR walk from MSB to LSB, result capture and IDLE output mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_idx      <= '0;
      r_trim     <= c_TRIM_MID;
      r_cal      <= c_TRIM_MID;
      r_cal_mode <= 1'b0;
      r_done     <= 1'b0;
    end else if (!bus.ena) begin
      // Abort: partial search is discarded, last good result is kept
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_cal_mode <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.manual_en) begin
            r_state    <= S_WARM;
            r_cnt      <= c_SETTLE_LD;
            r_idx      <= c_IDX_TOP;
            r_trim     <= c_TRIM_MID;
            r_cal_mode <= 1'b1;
          end else begin
            r_trim <= bus.manual_en ? bus.manual_code : r_cal;
          end
        end
        S_WARM: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_TRIAL;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_TRIAL: begin
          r_trim  <= r_trim | w_bit_mask;
          r_state <= S_SETTLE;
          r_cnt   <= c_SETTLE_LD;
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_SAMPLE;
            r_cnt   <= c_SAMPLE_LD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_trim <= w_decided_code;
            if (r_idx == '0) begin
              // Result is published on entry to DONE so done, cal_code and
              // the cal_mode release all line up on the same cycle
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cal      <= w_decided_code;
              r_cal_mode <= 1'b0;
            end else begin
              r_idx   <= r_idx - c_IDX_ONE;
              r_state <= S_TRIAL;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // OTA bias enable follows ena one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ota_en <= 1'b0;
    end else begin
      r_ota_en <= bus.ena;
    end
  end

  assign bus.trim_code = r_trim;
  assign bus.cal_code  = r_cal;
  assign bus.cal_mode  = r_cal_mode;
  assign bus.ota_en    = r_ota_en;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
